// File: rtl/mycpu_pkg.sv
// rtl/mycpu_pkg.sv - shared pipeline encodings and bus widths; MEM_LWLR_EN widens the EX->MS bus
package mycpu_pkg;

  localparam logic [2:0] LD_ALU = 3'b000;
  localparam logic [2:0] LD_LW  = 3'b001;
  localparam logic [2:0] LD_LB  = 3'b010;
  localparam logic [2:0] LD_LBU = 3'b011;
  localparam logic [2:0] LD_LH  = 3'b100;
  localparam logic [2:0] LD_LHU = 3'b101;
  localparam logic [2:0] LD_LWL = 3'b110;
  localparam logic [2:0] LD_LWR = 3'b111;

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    WAIT   = 2'd1,
    READY  = 2'd2,
    CANCEL = 2'd3
  } ms_state_e;

`ifdef MEM_LWLR_EN
  localparam int ES_TO_MS_BUS_WD = 106;
`else
  localparam int ES_TO_MS_BUS_WD = 74;
`endif
  localparam int MS_TO_WS_BUS_WD = 70;
  localparam int MS_FWD_BUS_WD   = 39;

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - load lane select, sign/zero extension and LWL/LWR merge (MEM_LWLR_EN)
module load_align
  import mycpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [2:0]        ld_op,
  input  logic [31:0]       alu_result,
  input  logic [DATA_W-1:0] rdata,
`ifdef MEM_LWLR_EN
  input  logic [31:0]       rt_old,
`endif
  output logic [31:0]       result
);

  logic [31:0] w;
  logic [7:0]  b;
  logic [15:0] h;

  generate
    if (DATA_W == 64) begin : g_w64
      assign w = alu_result[2] ? rdata[63:32] : rdata[31:0];
    end else begin : g_w32
      assign w = rdata;
    end
  endgenerate

  always_comb begin
    case (alu_result[1:0])
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = alu_result[1] ? w[31:16] : w[15:0];
  end

  always_comb begin
    result = alu_result;
    case (ld_op)
      LD_ALU: result = alu_result;
      LD_LW:  result = w;
      LD_LB:  result = {{24{b[7]}}, b};
      LD_LBU: result = {24'h0, b};
      LD_LH:  result = {{16{h[15]}}, h};
      LD_LHU: result = {16'h0, h};
`ifdef MEM_LWLR_EN
      LD_LWL: begin
        case (alu_result[1:0])
          2'd0:    result = {w[7:0],  rt_old[23:0]};
          2'd1:    result = {w[15:0], rt_old[15:0]};
          2'd2:    result = {w[23:0], rt_old[7:0]};
          default: result = w;
        endcase
      end
      LD_LWR: begin
        case (alu_result[1:0])
          2'd0:    result = w;
          2'd1:    result = {rt_old[31:24], w[31:8]};
          2'd2:    result = {rt_old[31:16], w[31:16]};
          default: result = {rt_old[31:8],  w[31:24]};
        endcase
      end
`else
      LD_LWL: result = w;
      LD_LWR: result = w;
`endif
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - MEM stage with variable-latency data SRAM response; MEM_LWLR_EN enables LWL/LWR
module mem_stage_lsu
  import mycpu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ES_BUS_W = ES_TO_MS_BUS_WD,
  parameter int WS_BUS_W = MS_TO_WS_BUS_WD
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     ws_allowin,
  output logic                     ms_allowin,
  input  logic                     es_to_ms_valid,
  input  logic [ES_BUS_W-1:0]      es_to_ms_bus,
  input  logic                     ms_flush,
  output logic                     ms_to_ws_valid,
  output logic [WS_BUS_W-1:0]      ms_to_ws_bus,
  input  logic                     data_sram_data_ok,
  input  logic [DATA_W-1:0]        data_sram_rdata,
  output logic [MS_FWD_BUS_WD-1:0] ms_fwd_bus
);

  ms_state_e           state;
  ms_state_e           accept_state;
  ms_state_e           leave_state;
  logic [ES_BUS_W-1:0] es_bus_r;
  logic [31:0]         ld_buf;
  logic [31:0]         align_out;
  logic [31:0]         final_result;
  logic [2:0]          ld_op_r;
  logic                mem_req_r;
  logic                gr_we_r;
  logic [4:0]          dest_r;
  logic [31:0]         alu_result_r;
  logic [31:0]         pc_r;
  logic                accept;
  logic                ms_live;
  logic                fwd_pending;

  assign pc_r         = es_bus_r[31:0];
  assign alu_result_r = es_bus_r[63:32];
  assign dest_r       = es_bus_r[68:64];
  assign gr_we_r      = es_bus_r[69];
  assign mem_req_r    = es_bus_r[70];
  assign ld_op_r      = es_bus_r[73:71];

  load_align #(.DATA_W(DATA_W)) u_load_align (
    .ld_op      (ld_op_r),
    .alu_result (alu_result_r),
    .rdata      (data_sram_rdata),
`ifdef MEM_LWLR_EN
    .rt_old     (es_bus_r[105:74]),
`endif
    .result     (align_out)
  );

  always_comb begin
    ms_live        = (state == WAIT) || (state == READY);
    ms_to_ws_valid = ((state == READY) || (state == WAIT && data_sram_data_ok)) && !ms_flush;
    ms_allowin     = (state == EMPTY) || (state == CANCEL && data_sram_data_ok)
                   || (ms_to_ws_valid && ws_allowin);
    accept         = es_to_ms_valid && ms_allowin;
    accept_state   = es_to_ms_bus[70] ? WAIT : READY;
    leave_state    = accept ? accept_state : EMPTY;
    // READY after a request means the response was parked in ld_buf
    final_result   = !mem_req_r ? alu_result_r : ((state == READY) ? ld_buf : align_out);
    fwd_pending    = (state == WAIT) && !data_sram_data_ok;
    ms_to_ws_bus   = ms_to_ws_valid ? {gr_we_r, dest_r, final_result, pc_r} : '0;
    ms_fwd_bus     = ms_live ? {gr_we_r, fwd_pending, dest_r, final_result} : '0;
  end

  always_ff @(posedge clk) begin
    if (accept) es_bus_r <= es_to_ms_bus;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= EMPTY;
      ld_buf <= 32'h0;
    end else begin
      case (state)
        EMPTY: if (accept) state <= accept_state;
        WAIT: begin
          if (ms_flush) begin
            state <= data_sram_data_ok ? EMPTY : CANCEL;
          end else if (data_sram_data_ok) begin
            if (ws_allowin) begin
              state <= leave_state;
            end else begin
              ld_buf <= align_out;
              state  <= READY;
            end
          end
        end
        READY: begin
          if (ms_flush)        state <= EMPTY;
          else if (ws_allowin) state <= leave_state;
        end
        // the orphaned response must drain before a new request can be matched
        CANCEL: if (data_sram_data_ok) state <= leave_state;
        default: state <= EMPTY;
      endcase
    end
  end

  a_data_ok_protocol: assert property (@(posedge clk) disable iff (!resetn)
    !(data_sram_data_ok && (state == EMPTY || state == READY)));

`ifndef MEM_LWLR_EN
  a_no_lwlr: assert property (@(posedge clk) disable iff (!resetn)
    !(ms_live && ld_op_r[2:1] == 2'b11));
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - randomized and directed bench for mem_stage_lsu at DATA_W 32 and 64
module tb_mem_stage_lsu;
  import mycpu_pkg::*;

  localparam int ES_W = ES_TO_MS_BUS_WD;
`ifdef MEM_LWLR_EN
  localparam int NOPS = 8;
`else
  localparam int NOPS = 6;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic ws_allowin = 1'b0;
  logic es_valid = 1'b0;
  logic ms_flush = 1'b0;
  logic data_ok = 1'b0;
  logic [63:0] rdata = '0;
  logic [2:0]  i_op = '0;
  logic        i_mreq = 1'b0;
  logic        i_gwe = 1'b0;
  logic [4:0]  i_dst = '0;
  logic [31:0] i_alu = '0, i_pc = '0, i_rt = '0;
  logic [ES_W-1:0] es_bus;

  logic        al32, al64, vl32, vl64;
  logic [69:0] wb32, wb64;
  logic [38:0] fw32, fw64;

  logic        m_occ = 1'b0, m_owed = 1'b0, m_have = 1'b0;
  logic [2:0]  m_op = '0;
  logic        m_mreq = 1'b0, m_gwe = 1'b0;
  logic [4:0]  m_dst = '0;
  logic [31:0] m_alu = '0, m_pc = '0, m_rt = '0;
  logic [31:0] m_data [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

`ifdef MEM_LWLR_EN
  assign es_bus = {i_rt, i_op, i_mreq, i_gwe, i_dst, i_alu, i_pc};
`else
  assign es_bus = {i_op, i_mreq, i_gwe, i_dst, i_alu, i_pc};
`endif

  mem_stage_lsu #(.DATA_W(32)) dut32 (
    .clk(clk), .resetn(resetn), .ws_allowin(ws_allowin), .ms_allowin(al32),
    .es_to_ms_valid(es_valid), .es_to_ms_bus(es_bus), .ms_flush(ms_flush),
    .ms_to_ws_valid(vl32), .ms_to_ws_bus(wb32), .data_sram_data_ok(data_ok),
    .data_sram_rdata(rdata[31:0]), .ms_fwd_bus(fw32)
  );

  mem_stage_lsu #(.DATA_W(64)) dut64 (
    .clk(clk), .resetn(resetn), .ws_allowin(ws_allowin), .ms_allowin(al64),
    .es_to_ms_valid(es_valid), .es_to_ms_bus(es_bus), .ms_flush(ms_flush),
    .ms_to_ws_valid(vl64), .ms_to_ws_bus(wb64), .data_sram_data_ok(data_ok),
    .data_sram_rdata(rdata), .ms_fwd_bus(fw64)
  );

  function automatic logic [31:0] ref_load(input int dw, input logic [2:0] op, input logic [31:0] a,
                                           input logic [63:0] rd, input logic [31:0] rt);
    logic [31:0] w, b, h;
    int o;
    o = int'(a[1:0]);
    w = (dw == 64 && a[2]) ? rd[63:32] : rd[31:0];
    b = (w >> (8 * o)) & 32'hFF;
    h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
    case (op)
      3'd1: return w;
      3'd2: return b[7] ? (b | 32'hFFFFFF00) : b;
      3'd3: return b;
      3'd4: return h[15] ? (h | 32'hFFFF0000) : h;
      3'd5: return h;
`ifdef MEM_LWLR_EN
      3'd6: return (w << (8 * (3 - o))) | (rt & (32'hFFFFFFFF >> (8 * (o + 1))));
      3'd7: return (w >> (8 * o)) | (rt & ~(32'hFFFFFFFF >> (8 * o)));
`else
      3'd6, 3'd7: return w;
`endif
      default: return a;
    endcase
  endfunction

  task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_inst(input logic [2:0] op, input logic mreq, input logic gwe, input logic [4:0] dst,
                          input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] rt);
    i_op = op; i_mreq = mreq; i_gwe = gwe; i_dst = dst; i_alu = alu; i_pc = pc; i_rt = rt;
  endtask

  task automatic rand_inst();
    int k;
    k = $urandom_range(0, NOPS - 1);
    i_op   = k[2:0];
    i_mreq = (i_op != LD_ALU) || ($urandom_range(0, 3) == 0);
    i_gwe  = (i_op != LD_ALU) ? 1'b1 : (i_mreq ? 1'b0 : 1'($urandom_range(0, 1)));
    i_dst  = 5'($urandom);
    i_alu  = $urandom;
    i_pc   = $urandom;
    i_rt   = $urandom;
  endtask

  // Model: one slot holding an instruction, plus whether an SRAM response is still owed to MS.
  task automatic step();
    logic [31:0] res [2];
    logic        live_done, exp_v, exp_a, pend, acc;
    logic [69:0] exp_wb;
    logic [38:0] exp_fw;
    for (int k = 0; k < 2; k++)
      res[k] = !m_mreq ? m_alu : (m_have ? m_data[k] : ref_load(k == 1 ? 64 : 32, m_op, m_alu, rdata, m_rt));
    live_done = m_occ && (!m_mreq || m_have || data_ok);
    exp_v     = live_done && !ms_flush;
    exp_a     = (!m_occ && (!m_owed || data_ok)) || (exp_v && ws_allowin);
    pend      = m_occ && m_mreq && !m_have && !data_ok;
    acc       = es_valid && exp_a && resetn;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      exp_wb = exp_v ? {m_gwe, m_dst, res[k], m_pc} : '0;
      exp_fw = m_occ ? {m_gwe, pend, m_dst, res[k]} : '0;
      chk(k == 1 ? "allowin64" : "allowin32", k == 1 ? 70'(al64) : 70'(al32), 70'(exp_a));
      chk(k == 1 ? "valid64" : "valid32", k == 1 ? 70'(vl64) : 70'(vl32), 70'(exp_v));
      chk(k == 1 ? "wbbus64" : "wbbus32", k == 1 ? wb64 : wb32, exp_wb);
      if (pend)
        chk(k == 1 ? "fwdhdr64" : "fwdhdr32", 70'((k == 1 ? fw64 : fw32) >> 32), 70'(exp_fw >> 32));
      else
        chk(k == 1 ? "fwd64" : "fwd32", 70'(k == 1 ? fw64 : fw32), 70'(exp_fw));
    end
    if (m_occ) begin
      if (ms_flush) begin
        m_owed = m_mreq && !m_have && !data_ok;
        m_occ  = 1'b0;
      end else if (live_done && ws_allowin) begin
        m_occ  = 1'b0;
        m_owed = 1'b0;
      end else if (m_mreq && !m_have && data_ok) begin
        m_have    = 1'b1;
        m_data[0] = res[0];
        m_data[1] = res[1];
        m_owed    = 1'b0;
      end
    end else if (m_owed && data_ok) begin
      m_owed = 1'b0;
    end
    if (acc) begin
      m_occ = 1'b1; m_have = 1'b0; m_owed = i_mreq;
      m_op = i_op; m_mreq = i_mreq; m_gwe = i_gwe; m_dst = i_dst;
      m_alu = i_alu; m_pc = i_pc; m_rt = i_rt;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    m_data[0] = '0;
    m_data[1] = '0;

    chk("pin_lb", 70'(ref_load(32, LD_LB, 32'h2, 64'h0080_0000, 32'h0)), 70'h0FFFFFF80);
    chk("pin_lhu64", 70'(ref_load(64, LD_LHU, 32'h6, 64'hBEEF_0000_0000_0000, 32'h0)), 70'h00000BEEF);
`ifdef MEM_LWLR_EN
    chk("pin_lwl", 70'(ref_load(32, LD_LWL, 32'h1, 64'h1122_3344, 32'hAABBCCDD)), 70'h03344CCDD);
    chk("pin_lwr", 70'(ref_load(32, LD_LWR, 32'h2, 64'h1122_3344, 32'hAABBCCDD)), 70'h0AABB1122);
`endif

    #1;
    chk("rst_allowin", 70'(al32), 70'h1);
    chk("rst_valid", 70'(vl64), 70'h0);
    chk("rst_fwd", 70'(fw32), 70'h0);
    chk("rst_wb", wb64, 70'h0);
    step();
    step();
    resetn = 1'b1;

    // ALU op passes straight through, one cycle
    set_inst(LD_ALU, 1'b0, 1'b1, 5'd3, 32'h1234, 32'h400, 32'h0);
    es_valid = 1'b1; ws_allowin = 1'b1;
    step();
    es_valid = 1'b0; #1;
    chk("alu_valid", 70'(vl32), 70'h1);
    chk("alu_res", 70'(wb32[63:32]), 70'h1234);
    step();
    #1; chk("alu_once", 70'(vl32), 70'h0);
    step();

    // LB with data_ok three cycles after entry
    set_inst(LD_LB, 1'b1, 1'b1, 5'd7, 32'h1000_0002, 32'h404, 32'h0);
    es_valid = 1'b1;
    step();
    es_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1; chk("lb_pending", 70'(fw32[37]), 70'h1);
      step();
    end
    data_ok = 1'b1; rdata = 64'h0080_0000; #1;
    chk("lb_res32", 70'(wb32[63:32]), 70'hFFFFFF80);
    chk("lb_res64", 70'(wb64[63:32]), 70'hFFFFFF80);
    step();
    data_ok = 1'b0;

    // LHU at offset 6 of a 64-bit beat
    set_inst(LD_LHU, 1'b1, 1'b1, 5'd9, 32'h2000_0006, 32'h408, 32'h0);
    es_valid = 1'b1;
    step();
    es_valid = 1'b0; data_ok = 1'b1; rdata = 64'hBEEF_0000_0000_0000; #1;
    chk("lhu_res64", 70'(wb64[63:32]), 70'h0000BEEF);
    step();
    data_ok = 1'b0;

    // LW response while WB stalls is held and emitted once
    set_inst(LD_LW, 1'b1, 1'b1, 5'd10, 32'h3000_0000, 32'h40C, 32'h0);
    es_valid = 1'b1;
    step();
    es_valid = 1'b0; ws_allowin = 1'b0; data_ok = 1'b1; rdata = 64'hCAFE_F00D; #1;
    chk("lw_dok_valid", 70'(vl32), 70'h1);
    step();
    data_ok = 1'b0; rdata = 64'h1357_9BDF_0246_8ACE; #1;
    chk("lw_held_valid", 70'(vl32), 70'h1);
    chk("lw_held_res", 70'(wb32[63:32]), 70'hCAFEF00D);
    step();
    ws_allowin = 1'b1; #1;
    chk("lw_out_res", 70'(wb64[63:32]), 70'hCAFEF00D);
    step();
    #1; chk("lw_nodup", 70'(vl32), 70'h0);
    step();

    // flush while waiting, then the orphan response is dropped
    set_inst(LD_LW, 1'b1, 1'b1, 5'd11, 32'h3000_0010, 32'h410, 32'h0);
    es_valid = 1'b1;
    step();
    es_valid = 1'b0; ms_flush = 1'b1; #1;
    chk("flush_allowin", 70'(al32), 70'h0);
    step();
    ms_flush = 1'b0;
    set_inst(LD_ALU, 1'b0, 1'b1, 5'd4, 32'h55, 32'h414, 32'h0);
    es_valid = 1'b1; #1;
    chk("cancel_allowin", 70'(al32), 70'h0);
    chk("cancel_valid", 70'(vl32), 70'h0);
    step();
    data_ok = 1'b1; rdata = 64'hDEAD_BEEF; #1;
    chk("drop_allowin", 70'(al64), 70'h1);
    chk("drop_valid", 70'(vl64), 70'h0);
    step();
    data_ok = 1'b0; es_valid = 1'b0; #1;
    chk("post_cancel_valid", 70'(vl32), 70'h1);
    chk("post_cancel_res", 70'(wb32[63:32]), 70'h55);
    step();

`ifdef MEM_LWLR_EN
    set_inst(LD_LWL, 1'b1, 1'b1, 5'd12, 32'h4000_0001, 32'h418, 32'hAABBCCDD);
    es_valid = 1'b1;
    step();
    es_valid = 1'b0; data_ok = 1'b1; rdata = 64'h1122_3344; #1;
    chk("lwl_res", 70'(wb32[63:32]), 70'h3344CCDD);
    step();
    data_ok = 1'b0;
`endif

    // reset while waiting returns to empty
    set_inst(LD_LW, 1'b1, 1'b1, 5'd13, 32'h5000_0000, 32'h41C, 32'h0);
    es_valid = 1'b1;
    step();
    es_valid = 1'b0; resetn = 1'b0; #1;
    chk("rstwait_allowin", 70'(al32), 70'h1);
    chk("rstwait_fwd", 70'(fw64), 70'h0);
    m_occ = 1'b0; m_owed = 1'b0; m_have = 1'b0;
    step();
    resetn = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      rand_inst();
      es_valid   = ($urandom_range(0, 9) < 7);
      ws_allowin = ($urandom_range(0, 3) != 0);
      ms_flush   = ($urandom_range(0, 9) == 0);
      data_ok    = m_owed && ($urandom_range(0, 9) < 4);
      rdata      = {$urandom, $urandom};
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
